// File: rtl/fifo_pkg.sv
// Shared sizing helpers and default thresholds for the single-clock FIFO family.
package fifo_pkg;

  localparam int DEF_DWIDTH    = 8;
  localparam int DEF_AWIDTH    = 4;
  localparam int DEF_AEMPTY_TH = 2;

  function automatic int fifoCountWidth(input int awidth);
    return awidth + 1;
  endfunction

  function automatic int fifoDepth(input int awidth);
    return 1 << awidth;
  endfunction

  function automatic int defAfullTh(input int awidth);
    return (1 << awidth) - 2;
  endfunction

  // Smallest address width able to index 'depth' entries.
  function automatic int depthToAwidth(input int depth);
    int w;
    w = 0;
    while ((1 << w) < depth) w++;
    return w;
  endfunction

endpackage

// File: rtl/fifo_sync_ram.sv
// FIFO storage array: synchronous write port with enable, asynchronous read port.
module fifo_sync_ram
  import fifo_pkg::*;
#(
  parameter int DWIDTH = DEF_DWIDTH,
  parameter int AWIDTH = DEF_AWIDTH
) (
  input  logic              clk,
  input  logic              i_wrEn,
  input  logic [AWIDTH-1:0] i_wrAddr,
  input  logic [DWIDTH-1:0] i_wrData,
  input  logic [AWIDTH-1:0] i_rdAddr,
  output logic [DWIDTH-1:0] o_rdData
);

  logic [DWIDTH-1:0] r_mem [fifoDepth(AWIDTH)];

  // Contents are deliberately not reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (i_wrEn) r_mem[i_wrAddr] <= i_wrData;
  end

  assign o_rdData = r_mem[i_rdAddr];

endmodule

// File: rtl/fifo_sync.sv
// Single-clock FIFO with occupancy count, threshold flags and error pulses.
// Define FIFO_FWFT_EN for first-word-fall-through reads; default is a registered read.
module fifo_sync
  import fifo_pkg::*;
#(
  parameter int DWIDTH    = DEF_DWIDTH,
  parameter int AWIDTH    = DEF_AWIDTH,
  parameter int AFULL_TH  = defAfullTh(AWIDTH),
  parameter int AEMPTY_TH = DEF_AEMPTY_TH
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               wr_en,
  input  logic [DWIDTH-1:0]                  wdata,
  input  logic                               rd_en,
  output logic [DWIDTH-1:0]                  rdata,
  output logic                               rvalid,
  output logic                               full,
  output logic                               empty,
  output logic                               almost_full,
  output logic                               almost_empty,
  output logic [fifoCountWidth(AWIDTH)-1:0]  count,
  output logic                               overflow,
  output logic                               underflow
);

  localparam logic [AWIDTH:0]   DEPTH_C   = {1'b1, {AWIDTH{1'b0}}};
  localparam logic [AWIDTH:0]   CNT_ONE   = {{AWIDTH{1'b0}}, 1'b1};
  localparam logic [AWIDTH-1:0] PTR_ONE   = {{(AWIDTH-1){1'b0}}, 1'b1};
  localparam logic [AWIDTH:0]   AFULL_C   = AFULL_TH[AWIDTH:0];
  localparam logic [AWIDTH:0]   AEMPTY_C  = AEMPTY_TH[AWIDTH:0];

  logic [AWIDTH-1:0] r_wrPtr;
  logic [AWIDTH-1:0] r_rdPtr;
  logic [AWIDTH:0]   r_count;
  logic              r_overflow;
  logic              r_underflow;
  logic              w_wrAccept;
  logic              w_rdAccept;
  logic [DWIDTH-1:0] w_ramData;

  assign full         = (r_count == DEPTH_C);
  assign empty        = (r_count == '0);
  assign almost_full  = (r_count >= AFULL_C);
  assign almost_empty = (r_count <= AEMPTY_C);
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

  // Full blocks writes even when a read is popping; empty never bypasses write data.
  assign w_wrAccept = wr_en && !full;
  assign w_rdAccept = rd_en && !empty;

  fifo_sync_ram #(
    .DWIDTH(DWIDTH),
    .AWIDTH(AWIDTH)
  ) u_ram (
    .clk     (clk),
    .i_wrEn  (w_wrAccept),
    .i_wrAddr(r_wrPtr),
    .i_wrData(wdata),
    .i_rdAddr(r_rdPtr),
    .o_rdData(w_ramData)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wrAccept) r_wrPtr <= r_wrPtr + PTR_ONE;
      if (w_rdAccept) r_rdPtr <= r_rdPtr + PTR_ONE;
      case ({w_wrAccept, w_rdAccept})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
      r_overflow  <= wr_en && !w_wrAccept;
      r_underflow <= rd_en && !w_rdAccept;
    end
  end

`ifdef FIFO_FWFT_EN
  // Head entry shown combinationally; masked to zero while nothing is stored.
  assign rvalid = !empty;
  assign rdata  = empty ? '0 : w_ramData;
`else
  logic [DWIDTH-1:0] r_rdata;
  logic              r_rvalid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= w_rdAccept;
      if (w_rdAccept) r_rdata <= w_ramData;
    end
  end

  assign rvalid = r_rvalid;
  assign rdata  = r_rdata;
`endif

endmodule
